// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing a single sfifo write port among NREQ requesters.
// One requester owns the port at a time for a burst of up to BURST beats. The
// arbiter tracks free FIFO slots in its own credit counter instead of using the
// FIFO's registered wfull flag (which lags occupancy by one cycle), so the FIFO
// can never be overflowed.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   req_valid   per-requester data valid
//   req_data    requester i data at bits [i*WIDTH +: WIDTH]
//   req_ready   per-requester accept (only the owner's bit can be high)
//   fifo_winc   write strobe to sfifo winc (combinational from the owner)
//   fifo_wdata  write data to sfifo wdata (zero when no write)
//   fifo_rpop   one pulse per accepted sfifo read, returns one credit
//   grant_id    current or last owner
//   busy        high while a requester holds the grant
//   credits     free FIFO slots as tracked by the arbiter (0..DEPTH)
//   err_ovf     sticky: a pop arrived while all DEPTH slots were already free
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      fifo_winc,
    output logic [WIDTH-1:0]          fifo_wdata,
    input  logic                      fifo_rpop,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    credits,
    output logic                      err_ovf
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH) + 1;   // wide enough to hold DEPTH itself
    localparam int BCW = $clog2(BURST) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [CW-1:0]  CRED_MAX  = CW'(DEPTH);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

    logic [0:0]       state,    state_nxt;
    logic [IDW-1:0]   rr_ptr,   rr_nxt;
    logic [IDW-1:0]   grant_nxt;
    logic [BCW-1:0]   beat_cnt, beat_nxt;
    logic [CW-1:0]    credits_nxt;
    logic             err_nxt;

    logic [WIDTH-1:0] data_arr [NREQ];
    logic             owner_valid;
    logic             credit_avail;
    logic             beat;
    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    int               cand_idx;

    // Successor of a requester index, wrapping at NREQ-1.
    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign owner_valid  = req_valid[grant_id];
    assign credit_avail = (credits != '0);
    assign beat         = (state == GRANT) && owner_valid && credit_avail;
    assign busy         = (state == GRANT);
    assign fifo_winc    = beat;
    assign fifo_wdata   = beat ? data_arr[grant_id] : '0;

    always_comb begin
        req_ready = '0;
        if (state == GRANT) begin
            req_ready[grant_id] = credit_avail;
        end
    end

    // Round-robin pick: scan offsets from the far end down to zero so that the
    // valid requester closest to rr_ptr is the last one written and wins.
    // NOTE: every signal assigned in an always_comb gets a default at the top of
    // the block; a path that leaves it unassigned would infer a latch.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr;
        cand_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_idx = int'(rr_ptr) + k;
            if (cand_idx >= NREQ) begin
                cand_idx = cand_idx - NREQ;
            end
            if (req_valid[IDW'(cand_idx)]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(cand_idx);
            end
        end
    end

    // Grant FSM. A stall on zero credits keeps the grant; a dropped valid or a
    // completed burst releases it and moves priority past the owner.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_id;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    grant_nxt = pick_id;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_nxt = IDLE;
                    rr_nxt    = next_id(grant_id);
                end else if (beat) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        rr_nxt    = next_id(grant_id);
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Credit bookkeeping: a beat consumes a slot, a pop returns one. A lone pop
    // with every slot already free cannot correspond to real FIFO data, so the
    // count saturates and the error flag latches.
    always_comb begin
        credits_nxt = credits;
        err_nxt     = err_ovf;
        case ({beat, fifo_rpop})
            2'b10: credits_nxt = credits - 1'b1;
            2'b01: begin
                if (credits == CRED_MAX) begin
                    err_nxt = 1'b1;
                end else begin
                    credits_nxt = credits + 1'b1;
                end
            end
            default: credits_nxt = credits;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            credits  <= CRED_MAX;
            err_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_nxt;
            credits  <= credits_nxt;
            err_ovf  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. Each requester is fed from a small source
// buffer; the expected FIFO write stream (owner id + data) is pushed into a
// scoreboard queue by the test sequence and a separate monitor pops and compares
// on every fifo_winc. Timing (bubbles, stalls) and credit/err state are checked
// directly from the test sequence.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_winc;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  fifo_rpop;
    logic [1:0]            grant_id;
    logic                  busy;
    logic [4:0]            credits;
    logic                  err_ovf;

    logic                  rpop_manual;
    logic                  follow;      // tie fifo_rpop to fifo_winc

    assign fifo_rpop = follow ? fifo_winc : rpop_manual;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .BURST(BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_winc (fifo_winc),
        .fifo_wdata(fifo_wdata),
        .fifo_rpop (fifo_rpop),
        .grant_id  (grant_id),
        .busy      (busy),
        .credits   (credits),
        .err_ovf   (err_ovf)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         winc_cnt = 0;
    int         winc_cyc[$];

    logic [7:0] src_mem [NREQ][64];
    int         src_len [NREQ];
    int         src_pos [NREQ];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int id, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) src_mem[id][src_len[id] + k] = 8'(base + k);
        src_len[id] += n;
    endtask

    task automatic expect_words(input int id, input logic [7:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = 2'(id);
            e.data = 8'(base + k);
            exp_q.push_back(e);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        follow      = 1'b0;
        rpop_manual = 1'b0;
        flush();
        winc_cnt = 0;
        repeat (2) step();
        rst = 1'b0;
        step();
        winc_cyc.delete();
    endtask

    // Wait until n writes have been seen since the last reset; returns just
    // after the negedge on which the n-th write was observed.
    task automatic wait_winc(input int n, input int budget, input string name);
        int b = 0;
        while (winc_cnt < n && b < budget) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (winc_cnt < n) check({name, "_timeout"}, winc_cnt, n);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester model: hold data until accepted, then advance.
    initial begin
        logic [NREQ-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < NREQ; i++)
                    if (acc[i] && src_pos[i] < src_len[i]) src_pos[i]++;
            end
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (src_pos[i] < src_len[i]);
                req_data[i*WIDTH +: WIDTH] = '0;
                if (req_valid[i]) req_data[i*WIDTH +: WIDTH] = src_mem[i][src_pos[i]];
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && fifo_winc) begin
            winc_cnt++;
            winc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", int'(fifo_wdata), -1);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", int'(fifo_wdata), int'(e.data));
                check("sb_grant_id", int'(grant_id), int'(e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        follow      = 1'b0;
        rpop_manual = 1'b0;
        flush();

        // ---------------- reset state ----------------
        do_reset();
        check("rst_credits",   int'(credits),   16);
        check("rst_busy",      int'(busy),      0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_winc",      int'(fifo_winc), 0);
        check("rst_err_ovf",   int'(err_ovf),   0);
        check("rst_grant_id",  int'(grant_id),  0);

        // ---------------- 1: burst limit ----------------
        load(2, 8'hA0, 6);
        expect_words(2, 8'hA0, 6);
        wait_winc(6, 60, "t1");
        repeat (3) step();
        check("t1_writes", winc_cyc.size(), 6);
        if (winc_cyc.size() == 6)
            for (int j = 1; j < 6; j++)
                check("t1_gap", winc_cyc[j] - winc_cyc[j-1], (j == 4) ? 2 : 1);
        check("t1_credits", int'(credits), 10);
        check("t1_busy",    int'(busy),    0);
        check("t1_sb_empty", exp_q.size(), 0);

        // ---------------- 2: round robin ----------------
        do_reset();
        follow = 1'b1;
        load(0, 8'h00, 8);
        load(1, 8'h10, 4);
        load(2, 8'h20, 4);
        load(3, 8'h30, 4);
        expect_words(0, 8'h00, 4);
        expect_words(1, 8'h10, 4);
        expect_words(2, 8'h20, 4);
        expect_words(3, 8'h30, 4);
        expect_words(0, 8'h04, 4);
        wait_winc(20, 200, "t2");
        repeat (3) step();
        check("t2_writes", winc_cyc.size(), 20);
        if (winc_cyc.size() == 20)
            for (int j = 1; j < 20; j++)
                check("t2_gap", winc_cyc[j] - winc_cyc[j-1], (j % 4 == 0) ? 2 : 1);
        check("t2_credits", int'(credits), 16);
        check("t2_sb_empty", exp_q.size(), 0);
        follow = 1'b0;

        // ---------------- 3: credit exhaustion ----------------
        do_reset();
        load(0, 8'h40, 20);
        expect_words(0, 8'h40, 17);
        wait_winc(16, 200, "t3");
        repeat (5) step();
        check("t3_stall_busy",    int'(busy),      1);
        check("t3_stall_ready",   int'(req_ready), 0);
        check("t3_stall_credits", int'(credits),   0);
        check("t3_stall_winc",    int'(fifo_winc), 0);
        check("t3_stall_count",   winc_cnt,        16);
        rpop_manual = 1'b1;
        step();
        rpop_manual = 1'b0;
        check("t3_pop_credits", int'(credits),   1);
        check("t3_pop_ready",   int'(req_ready), 1);
        check("t3_pop_winc",    int'(fifo_winc), 1);
        repeat (4) step();
        check("t3_final_count",   winc_cnt,      17);
        check("t3_final_credits", int'(credits), 0);
        check("t3_final_busy",    int'(busy),    1);
        check("t3_sb_empty", exp_q.size(), 0);

        // ---------------- 4: beat and pop together ----------------
        do_reset();
        load(3, 8'hB0, 11);
        expect_words(3, 8'hB0, 11);
        wait_winc(11, 100, "t4_fill");
        repeat (3) step();
        check("t4_pre_credits", int'(credits), 5);
        check("t4_pre_busy",    int'(busy),    0);
        follow = 1'b1;
        load(3, 8'hBB, 1);
        expect_words(3, 8'hBB, 1);
        wait_winc(12, 20, "t4_beat");
        check("t4_winc",        int'(fifo_winc), 1);
        check("t4_rpop",        int'(fifo_rpop), 1);
        check("t4_credits_now", int'(credits),   5);
        step();
        check("t4_credits_after", int'(credits), 5);
        follow = 1'b0;
        check("t4_sb_empty", exp_q.size(), 0);

        // ---------------- 5: spurious pop ----------------
        do_reset();
        step();
        rpop_manual = 1'b1;
        step();
        rpop_manual = 1'b0;
        check("t5_credits", int'(credits), 16);
        check("t5_err_set", int'(err_ovf), 1);
        repeat (3) step();
        check("t5_err_sticky", int'(err_ovf), 1);
        check("t5_credits_hold", int'(credits), 16);
        do_reset();
        check("t5_err_cleared", int'(err_ovf), 0);

        // ---------------- 6: reset mid-burst ----------------
        do_reset();
        load(2, 8'h60, 1);           // moves round-robin pointer past 2
        expect_words(2, 8'h60, 1);
        wait_winc(1, 20, "t6_pre");
        repeat (3) step();
        load(1, 8'h70, 4);
        expect_words(1, 8'h70, 2);   // two beats are seen before the reset hits
        wait_winc(3, 40, "t6_burst");
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_winc",    int'(fifo_winc),  0);
        check("t6_rst_ready",   int'(req_ready),  0);
        check("t6_rst_busy",    int'(busy),       0);
        check("t6_rst_wdata",   int'(fifo_wdata), 0);
        check("t6_rst_credits", int'(credits),    16);
        check("t6_rst_grant",   int'(grant_id),   0);
        flush();
        winc_cnt = 0;
        repeat (2) step();
        rst = 1'b0;
        step();
        load(1, 8'h80, 1);
        load(3, 8'h90, 1);
        expect_words(1, 8'h80, 1);   // pointer restarted at 0, so 1 beats 3
        expect_words(3, 8'h90, 1);
        wait_winc(2, 40, "t6_post");
        repeat (3) step();
        check("t6_post_credits", int'(credits), 14);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
